// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory unit.
// Holds RISC-V funct3 access-size constants, the size and FSM state enums,
// and helpers for size legality and byte-lane mask generation.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    SZ_B  = F3_B,
    SZ_H  = F3_H,
    SZ_W  = F3_W,
    SZ_BU = F3_BU,
    SZ_HU = F3_HU
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // True for the five funct3 encodings this unit implements.
  function automatic logic size_legal(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Byte-lane enables for an access of size f3 starting at byte offset off
  // within an 8-lane word; narrower words use the low lanes only.
  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: DEPTH x DATA_W storage with per-byte write enables and a
// registered read port that only updates when a read is requested, so a
// captured word survives later writes to the same location.
module dmem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       i_re,
  input  logic [DATA_W/8-1:0]        i_be,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  input  logic [DATA_W-1:0]          i_wdata,
  output logic [DATA_W-1:0]          o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-masked write and enabled synchronous read of the addressed word.
  // NOTE: the array and its read register have no reset; clearing a RAM costs
  // a write port sweep and the contents are never relied upon before a store.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W/8; b++) begin
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: single-outstanding load/store unit in front of dmem_bank.
// Handles address range and size checks, byte-lane alignment of stores,
// extraction and sign/zero extension of loads, and the IDLE/RESP handshake.
// Optional build macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned
// halfword/word accesses fault; otherwise the low address bits are cleared.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  logic              w_accept;
  logic              w_legal;
  logic              w_in_range;
  logic              w_err;
  logic              w_re;
  logic [OFF_W-1:0]  w_off;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_bank_rdata;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_ext;

  state_e            r_state;
  logic              r_resp_valid;
  logic              r_err;
  logic              r_we;
  size_e             r_size;
  logic [OFF_W-1:0]  r_off;

  // A new request may enter whenever the response slot is empty or draining.
  assign req_ready  = !r_resp_valid || resp_ready;
  assign w_accept   = req_valid && req_ready;
  assign w_legal    = size_legal(req_size);
  assign w_in_range = (req_addr >> (IDX_W + OFF_W)) == 32'd0;

  // Natural alignment of the byte offset: halves clear bit 0, words bits 1:0.
  // NOTE: every output of a combinational block gets a value before any
  // branch, otherwise an unassigned path infers a latch.
  always_comb begin
    w_off = req_addr[OFF_W-1:0];
    case (req_size)
      F3_H, F3_HU: w_off[0]   = 1'b0;
      F3_W:        w_off[1:0] = 2'b00;
      default:     ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Any bit cleared by alignment means the request was misaligned.
  logic w_misalign;
  assign w_misalign = (w_off != req_addr[OFF_W-1:0]);
  assign w_err      = !w_legal || !w_in_range || w_misalign;
`else
  assign w_err      = !w_legal || !w_in_range;
`endif

  assign w_re    = w_accept && !req_we && !w_err;
  assign w_be    = (w_accept && req_we && !w_err) ? NB'(lane_mask(req_size, 3'(w_off))) : '0;
  assign w_wdata = req_wdata << {w_off, 3'b000};

  dmem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .clk     (clk),
    .i_re    (w_re),
    .i_be    (w_be),
    .i_addr  (req_addr[IDX_W+OFF_W-1:OFF_W]),
    .i_wdata (w_wdata),
    .o_rdata (w_bank_rdata)
  );

  // Handshake FSM: capture request attributes on accept, release on consume.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= SZ_B;
      r_off        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) r_state <= ST_RESP;
        ST_RESP: if (!w_accept && resp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_accept) begin
        r_resp_valid <= 1'b1;
        r_err        <= w_err;
        r_we         <= req_we;
        r_size       <= size_e'(req_size);
        r_off        <= w_off;
      end else if (resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign w_shifted = w_bank_rdata >> {r_off, 3'b000};

  // Load extension from the captured word according to the captured size.
  always_comb begin
    w_ext = '0;
    case (r_size)
      SZ_B:    w_ext = DATA_W'(signed'(w_shifted[7:0]));
      SZ_BU:   w_ext = DATA_W'(w_shifted[7:0]);
      SZ_H:    w_ext = DATA_W'(signed'(w_shifted[15:0]));
      SZ_HU:   w_ext = DATA_W'(w_shifted[15:0]);
      SZ_W:    w_ext = DATA_W'(signed'(w_shifted[31:0]));
      default: w_ext = '0;
    endcase
  end

  // Stores, faults and the empty slot all present zero data.
  assign resp_rdata = (r_resp_valid && !r_err && !r_we) ? w_ext : '0;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: scoreboard bench for dmem_unit (DATA_W=32, DEPTH=1024).
// Expected results come from a byte-array reference model and are queued at
// acceptance; a negedge monitor pops and compares each consumed response.
module tb_dmem_unit;
  import dmem_pkg::*;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 1024;
  localparam int MEM_BYTES = DEPTH * DATA_W / 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_ready = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [0:MEM_BYTES-1];
  int         n_vec  = 0;
  int         n_miss = 0;
  int         last_wait;

  dmem_unit #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: applies a store to the byte array or computes a load.
  task automatic model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int          n;
    int          a;
    logic        legal;
    logic        mis;
    logic [31:0] v;
    legal = (size == 3'b000) || (size == 3'b001) || (size == 3'b010) ||
            (size == 3'b100) || (size == 3'b101);
    n     = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
    mis   = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    err   = !legal || (addr >= 32'(MEM_BYTES));
`ifdef DMEM_MISALIGN_TRAP_EN
    err   = err || mis;
`endif
    a     = int'(addr) & ~(n - 1);
    rdata = 32'd0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < n; k++) mdl[a+k] = wdata[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mdl[a+k];
        if (!size[2]) begin
          if (n == 1)      v = {{24{v[7]}}, v[7:0]};
          else if (n == 2) v = {{16{v[15]}}, v[15:0]};
        end
        rdata = v;
      end
    end
  endtask

  task automatic push(input string tag, input logic we, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.tag = tag;
    model(we, size, addr, wdata, e.rdata, e.err);
    sb.push_back(e);
  endtask

  // Present one request and wait (bounded) until it is accepted.
  task automatic issue(input string tag, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int waits;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    waits     = 0;
    @(negedge clk);
    while (!req_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    last_wait = waits;
    if (!req_ready) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    else            push(tag, we, size, addr, wdata);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Response monitor: every consumed response must match the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
        check({e.tag, "_err"}, 64'(resp_err), 64'(e.err));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] d;

    // Reset values, with resp_ready low so req_ready depends on resp_valid.
    #1 reset_n = 1'b0;
    #2;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_resp_err",   64'(resp_err),   64'd0);
    check("rst_req_ready",  64'(req_ready),  64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    resp_ready = 1'b1;

    // Byte/half extraction and extension from a stored word.
    issue("sw_10",  1'b1, F3_W,  32'h10, 32'hDEADBEEF);
    issue("lb_13",  1'b0, F3_B,  32'h13, 32'h0);
    issue("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0);
    issue("lh_12",  1'b0, F3_H,  32'h12, 32'h0);
    issue("lhu_12", 1'b0, F3_HU, 32'h12, 32'h0);
    issue("lb_10",  1'b0, F3_B,  32'h10, 32'h0);
    issue("lh_10",  1'b0, F3_H,  32'h10, 32'h0);
    issue("lw_10",  1'b0, F3_W,  32'h10, 32'h0);

    // Partial stores touch only their lanes; upper wdata bits are ignored.
    issue("sw_20",  1'b1, F3_W,  32'h20, 32'h11223344);
    issue("sb_21",  1'b1, F3_B,  32'h21, 32'hAAAAAA7F);
    issue("lw_20a", 1'b0, F3_W,  32'h20, 32'h0);
    issue("sh_22",  1'b1, F3_H,  32'h22, 32'h55559ABC);
    issue("lbu_22", 1'b0, F3_BU, 32'h22, 32'h0);
    issue("lw_20b", 1'b0, F3_W,  32'h20, 32'h0);
    idle();
    drain();

    // Streaming store/load pairs to one word at full rate.
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      issue("stream_sw", 1'b1, F3_W, 32'h40, d);
      check("stream_sw_wait", 64'(last_wait), 64'd0);
      issue("stream_lw", 1'b0, F3_W, 32'h40, 32'h0);
      check("stream_lw_wait", 64'(last_wait), 64'd0);
    end
    idle();
    drain();

    // Misaligned accesses: trap or silently aligned depending on the build.
    issue("mis_sw_100",  1'b1, F3_W,  32'h100, 32'hCAFEF00D);
    issue("mis_lw_102",  1'b0, F3_W,  32'h102, 32'h0);
    issue("mis_sw_103",  1'b1, F3_W,  32'h103, 32'h00000055);
    issue("mis_lw_100a", 1'b0, F3_W,  32'h100, 32'h0);
    issue("mis_sh_101",  1'b1, F3_H,  32'h101, 32'h00001234);
    issue("mis_lw_100b", 1'b0, F3_W,  32'h100, 32'h0);
    issue("mis_lhu_103", 1'b0, F3_HU, 32'h103, 32'h0);

    // Range boundary and illegal sizes: fault, zero data, no write.
    issue("sw_0",        1'b1, F3_W,   32'h0,        32'h12345678);
    issue("oor_sw_1000", 1'b1, F3_W,   32'h1000,     32'hFFFFFFFF);
    issue("oor_lw_1000", 1'b0, F3_W,   32'h1000,     32'h0);
    issue("oor_lb_top",  1'b0, F3_B,   32'hFFFFFFFC, 32'h0);
    issue("lw_0",        1'b0, F3_W,   32'h0,        32'h0);
    issue("sb_fff",      1'b1, F3_B,   32'hFFF,      32'h00000081);
    issue("lb_fff",      1'b0, F3_B,   32'hFFF,      32'h0);
    issue("sw_30",       1'b1, F3_W,   32'h30,       32'h0BADF00D);
    issue("ill_st_011",  1'b1, 3'b011, 32'h30,       32'h0);
    issue("ill_ld_110",  1'b0, 3'b110, 32'h30,       32'h0);
    issue("ill_st_111",  1'b1, 3'b111, 32'h30,       32'h0);
    issue("lw_30",       1'b0, F3_W,   32'h30,       32'h0);
    idle();
    drain();

    // Backpressure: response held stable, next request blocked until release.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue("bp_lw_10", 1'b0, F3_W, 32'h10, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = F3_W;
    req_addr  = 32'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_resp_valid", 64'(resp_valid), 64'd1);
      check("bp_resp_rdata", 64'(resp_rdata), 64'hDEADBEEF);
      check("bp_resp_err",   64'(resp_err),   64'd0);
      check("bp_req_ready",  64'(req_ready),  64'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(req_ready), 64'd1);
    if (req_ready) push("bp_lw_20", 1'b0, F3_W, 32'h20, 32'h0);
    idle();
    drain();

    // Reset during a pending response discards it immediately.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue("rst_lw_20", 1'b0, F3_W, 32'h20, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_resp_valid", 64'(resp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("mid_rst_resp_err",   64'(resp_err),   64'd0);
    check("mid_rst_req_ready",  64'(req_ready),  64'd1);
    sb.delete();
    @(negedge clk);
    reset_n    = 1'b1;
    resp_ready = 1'b1;

    // Memory survives reset.
    issue("post_rst_lw_20", 1'b0, F3_W, 32'h20, 32'h0);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
